// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-master arbiter for one synchronous single-port RAM. Fixed
//             4-cycle transaction (grant, access, response, ack), all outputs
//             registered. Define RR_ARB_EN for round-robin arbitration;
//             the default build uses fixed priority with m0 highest.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_gnt,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              winner_q, winner_d;   // 1 = m1 owns the current transaction
    logic              we_lat_q, we_lat_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic              m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
    logic              busy_q, busy_d;
    logic              w_any_req;
    logic              w_pick;               // 1 = m1 wins this arbitration
`ifdef RR_ARB_EN
    logic              last_q, last_d;       // 1 = m1 was granted last
`endif

    assign w_any_req = m0_req | m1_req;

    always_comb begin
        w_pick = 1'b0;
`ifdef RR_ARB_EN
        if (m0_req && m1_req) w_pick = ~last_q;
        else                  w_pick = m1_req;
`else
        w_pick = ~m0_req;
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= S_IDLE;
            winner_q    <= 1'b0;
            we_lat_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RR_ARB_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            we_lat_q    <= we_lat_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_gnt_q    <= m0_gnt_d;
            m1_gnt_q    <= m1_gnt_d;
            busy_q      <= busy_d;
`ifdef RR_ARB_EN
            last_q      <= last_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_any_req) state_d = S_ACC;
            S_ACC:   state_d = S_RSP;
            S_RSP:   state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered-output next values
    always_comb begin
        winner_d    = winner_q;
        we_lat_d    = we_lat_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_gnt_d    = m0_gnt_q;
        m1_gnt_d    = m1_gnt_q;
        busy_d      = (state_d != S_IDLE);
`ifdef RR_ARB_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    winner_d    = w_pick;
                    we_lat_d    = w_pick ? m1_we    : m0_we;
                    mem_we_d    = w_pick ? m1_we    : m0_we;
                    mem_addr_d  = w_pick ? m1_addr  : m0_addr;
                    mem_wdata_d = w_pick ? m1_wdata : m0_wdata;
                    m0_gnt_d    = ~w_pick;
                    m1_gnt_d    = w_pick;
`ifdef RR_ARB_EN
                    last_d      = w_pick;
`endif
                end
            end
            S_RSP: begin
                // Read data left the RAM one cycle after the access edge
                if (winner_q) begin
                    m1_ack_d = 1'b1;
                    if (!we_lat_q) m1_rdata_d = mem_rdata;
                end else begin
                    m0_ack_d = 1'b1;
                    if (!we_lat_q) m0_rdata_d = mem_rdata;
                end
            end
            S_ACK: begin
                m0_gnt_d = 1'b0;
                m1_gnt_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter with a behavioural RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              res;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_ack, m1_ack, m0_gnt, m1_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .res(res),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_gnt(m0_gnt),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_gnt(m1_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    initial begin
        for (int k = 0; k < (1 << ADDR_W); k++) ram[k] = '0;
    end
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic              sel;      // 1 = m1
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_r0;
        logic [DATA_W-1:0] exp_r1;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic req, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (sel) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        res = 1'b1;
    endtask

    // One full transaction from IDLE, checked cycle by cycle
    task automatic do_txn(input vec_t v, input string tag);
        @(negedge clk);
        drive(v.sel, 1'b1, v.we, v.addr, v.wdata);
        @(negedge clk);
        check({tag, " gnt"},       32'(v.sel ? m1_gnt : m0_gnt), 32'd1);
        check({tag, " other_gnt"}, 32'(v.sel ? m0_gnt : m1_gnt), 32'd0);
        check({tag, " mem_we"},    32'(mem_we), 32'(v.we));
        check({tag, " mem_addr"},  32'(mem_addr), 32'(v.addr));
        check({tag, " mem_wdata"}, 32'(mem_wdata), 32'(v.wdata));
        check({tag, " busy"},      32'(busy), 32'd1);
        @(negedge clk);
        check({tag, " mem_we_E1"}, 32'(mem_we), 32'd0);
        check({tag, " early_ack"}, 32'(m0_ack | m1_ack), 32'd0);
        @(negedge clk);
        check({tag, " ack"},       32'(v.sel ? m1_ack : m0_ack), 32'd1);
        check({tag, " other_ack"}, 32'(v.sel ? m0_ack : m1_ack), 32'd0);
        check({tag, " m0_rdata"},  32'(m0_rdata), 32'(v.exp_r0));
        check({tag, " m1_rdata"},  32'(m1_rdata), 32'(v.exp_r1));
        drive(v.sel, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check({tag, " ack_end"},   32'(m0_ack | m1_ack), 32'd0);
        check({tag, " gnt_end"},   32'(m0_gnt | m1_gnt), 32'd0);
        check({tag, " busy_end"},  32'(busy), 32'd0);
    endtask

    initial begin : main
        int acks;
        bit seen;
        logic exp_owner;
        vec_t v;

        vecs[0] = '{1'b0, 1'b1, 13'h0123, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 13'h0123, 8'h00, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 13'h1FFF, 8'h3C, 8'hA5, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 8'hA5, 8'h3C};
        vecs[4] = '{1'b1, 1'b0, 13'h0123, 8'h00, 8'hA5, 8'hA5};
        vecs[5] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 8'h3C, 8'hA5};
        vecs[6] = '{1'b0, 1'b1, 13'h0000, 8'h5A, 8'h3C, 8'hA5};
        vecs[7] = '{1'b1, 1'b1, 13'h0000, 8'hC3, 8'h3C, 8'hA5};
        vecs[8] = '{1'b0, 1'b0, 13'h0000, 8'h00, 8'hC3, 8'hA5};

        res = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check("reset gnt",      32'({m0_gnt, m1_gnt}), 32'd0);
        check("reset ack",      32'({m0_ack, m1_ack}), 32'd0);
        check("reset mem_we",   32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata",32'(mem_wdata), 32'd0);
        check("reset rdata",    32'({m0_rdata, m1_rdata}), 32'd0);
        check("reset busy",     32'(busy), 32'd0);
        res = 1'b1;

        for (int i = 0; i < 9; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous reads right after reset: m0 first in both policies
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 13'h0123, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        @(negedge clk);
        check("simul first_gnt", 32'({m0_gnt, m1_gnt}), 32'b10);
        repeat (2) @(negedge clk);
        check("simul m0_ack",    32'({m0_ack, m1_ack}), 32'b10);
        check("simul m0_rdata",  32'(m0_rdata), 32'hA5);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check("simul second_gnt", 32'({m0_gnt, m1_gnt}), 32'b01);
        repeat (2) @(negedge clk);
        check("simul m1_ack",    32'({m0_ack, m1_ack}), 32'b01);
        check("simul m1_rdata",  32'(m1_rdata), 32'h3C);
        check("simul m0_keep",   32'(m0_rdata), 32'hA5);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Both masters request continuously for 8 transactions
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 13'h0000, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 13'h0000, 8'h00);
        for (int i = 0; i < 8; i++) begin
`ifdef RR_ARB_EN
            exp_owner = i[0];
`else
            exp_owner = 1'b0;
`endif
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                @(negedge clk);
                check("cont one_gnt", 32'(m0_gnt & m1_gnt), 32'd0);
                if (m0_ack | m1_ack) begin
                    seen = 1'b1;
                    check($sformatf("cont owner%0d", i), 32'({m0_ack, m1_ack}),
                          exp_owner ? 32'b01 : 32'b10);
                end
            end
            if (!seen) check($sformatf("cont timeout%0d", i), 32'd0, 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) @(negedge clk);
        check("cont idle", 32'(busy), 32'd0);

        // Reset asserted during the response phase of an m1 read
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        repeat (2) @(negedge clk);
        check("abort in_rsp", 32'({busy, m1_gnt}), 32'b11);
        #2 res = 1'b0;
        #1;
        check("abort ack",    32'(m1_ack), 32'd0);
        check("abort gnt",    32'(m1_gnt), 32'd0);
        check("abort mem_we", 32'(mem_we), 32'd0);
        check("abort busy",   32'(busy), 32'd0);
        check("abort mem_addr", 32'(mem_addr), 32'd0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("abort held_ack", 32'(m1_ack), 32'd0);
        res = 1'b1;
        @(negedge clk);
        check("abort post_ack", 32'(m0_ack | m1_ack), 32'd0);
        v = '{1'b1, 1'b0, 13'h1FFF, 8'h00, 8'h00, 8'h3C};
        do_txn(v, "rereq");

        // m0 drops req the cycle after grant
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 13'h0000, 8'h00);
        @(negedge clk);
        check("drop gnt", 32'(m0_gnt), 32'd1);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (m0_ack) acks++;
        end
        check("drop ack_count", 32'(acks), 32'd1);
        check("drop m0_rdata",  32'(m0_rdata), 32'hC3);
        check("drop busy",      32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
